// File: rtl/mem_bist.sv
// Single-port synchronous RAM with a registered read path and a March C- self-test engine.
// Each BIST read is registered and then compared on the next edge. The test stops at the first mismatch.
module mem_bist #(
    parameter int ADR_SIZE  = 4,
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADR_SIZE-1:0]  adress,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 bist_start,
    output logic                 bist_busy,
    output logic                 bist_done,
    output logic                 bist_fail,
    output logic [ADR_SIZE-1:0]  fail_adr,
    input  logic                 inj_en,
    input  logic [ADR_SIZE-1:0]  inj_adr
);
    localparam int N = 1 << ADR_SIZE;

    // S_FLUSH holds the engine for one cycle so the final read can be compared.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           elem_q, elem_d;
    logic                 phase_q, phase_d;
    logic [ADR_SIZE-1:0]  badr_q, badr_d;
    logic                 cmp_vld_q, cmp_vld_d;
    logic [ADR_SIZE-1:0]  cmp_adr_q, cmp_adr_d;
    logic [DATA_SIZE-1:0] cmp_data_q, cmp_data_d;
    logic [DATA_SIZE-1:0] cmp_exp_q, cmp_exp_d;
    logic                 fail_q, fail_d;
    logic [ADR_SIZE-1:0]  fail_adr_q, fail_adr_d;
    logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [DATA_SIZE-1:0] ram_q [N];

    logic                 ram_we;
    logic [ADR_SIZE-1:0]  ram_wadr;
    logic [DATA_SIZE-1:0] ram_wdata;
    logic [DATA_SIZE-1:0] func_word, bist_word;
    logic                 busy, mismatch, start;
    logic                 is_rw, op_rd, ones_rd, ones_wr, adv, desc, term;

    // Injected fault: bit 0 of the selected word reads back as 0.
    assign func_word = ram_q[adress] & ~DATA_SIZE'(inj_en && (adress == inj_adr));
    assign bist_word = ram_q[badr_q] & ~DATA_SIZE'(inj_en && (badr_q == inj_adr));

    assign busy     = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign mismatch = cmp_vld_q && (cmp_data_q != cmp_exp_q);
    assign start    = bist_start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // M0 = w0, M1..M4 = (read, write) pairs, M5 = r0. M3 and M4 run in descending order.
    assign is_rw   = (elem_q != 3'd0) && (elem_q != 3'd5);
    assign op_rd   = (is_rw && !phase_q) || (elem_q == 3'd5);
    assign ones_rd = (elem_q == 3'd2) || (elem_q == 3'd4);
    assign ones_wr = (elem_q == 3'd1) || (elem_q == 3'd3);
    assign adv     = !is_rw || phase_q;
    assign desc    = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign term    = desc ? (badr_q == '0) : (badr_q == '1);

    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        phase_d    = phase_q;
        badr_d     = badr_q;
        cmp_vld_d  = 1'b0;
        cmp_adr_d  = cmp_adr_q;
        cmp_data_d = cmp_data_q;
        cmp_exp_d  = cmp_exp_q;
        fail_d     = fail_q;
        fail_adr_d = fail_adr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ram_we     = 1'b0;
        ram_wadr   = adress;
        ram_wdata  = wr_data;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (wr_en) begin
                    ram_we = 1'b1;
                end else if (rd_en) begin
                    rd_data_d  = func_word;
                    rd_valid_d = 1'b1;
                end
                if (start) begin
                    state_d    = S_RUN;
                    elem_d     = 3'd0;
                    phase_d    = 1'b0;
                    badr_d     = '0;
                    fail_d     = 1'b0;
                    fail_adr_d = '0;
                end
            end
            S_RUN: begin
                if (mismatch) begin
                    fail_d     = 1'b1;
                    fail_adr_d = cmp_adr_q;
                    state_d    = S_DONE;
                end else begin
                    if (op_rd) begin
                        cmp_vld_d  = 1'b1;
                        cmp_adr_d  = badr_q;
                        cmp_data_d = bist_word;
                        cmp_exp_d  = ones_rd ? '1 : '0;
                    end else begin
                        ram_we    = 1'b1;
                        ram_wadr  = badr_q;
                        ram_wdata = ones_wr ? '1 : '0;
                    end
                    phase_d = is_rw && !phase_q;
                    if (adv) begin
                        if (!term) begin
                            badr_d = desc ? badr_q - ADR_SIZE'(1) : badr_q + ADR_SIZE'(1);
                        end else if (elem_q == 3'd5) begin
                            state_d = S_FLUSH;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            badr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? '1 : '0;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (mismatch) begin
                    fail_d     = 1'b1;
                    fail_adr_d = cmp_adr_q;
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            elem_q     <= '0;
            phase_q    <= 1'b0;
            badr_q     <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_adr_q  <= '0;
            cmp_data_q <= '0;
            cmp_exp_q  <= '0;
            fail_q     <= 1'b0;
            fail_adr_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            phase_q    <= phase_d;
            badr_q     <= badr_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_adr_q  <= cmp_adr_d;
            cmp_data_q <= cmp_data_d;
            cmp_exp_q  <= cmp_exp_d;
            fail_q     <= fail_d;
            fail_adr_q <= fail_adr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Reset does not clear the array contents.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) ram_q[ram_wadr] <= ram_wdata;
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign bist_busy = busy;
    assign bist_done = (state_q == S_DONE);
    assign bist_fail = fail_q;
    assign fail_adr  = fail_adr_q;

endmodule

// File: tb/tb_mem_bist.sv
// Randomised bench for mem_bist: functional port behaviour and March C- timing and fail reporting,
// with the expected results computed by an operation-list reference model.
module tb_mem_bist;
    localparam int AW = 4, DW = 8, AWB = 2, DWB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] adress = '0, inj_adr = '0, fail_adr;
    logic          wr_en = 0, rd_en = 0, bist_start = 0, inj_en = 0;
    logic [DW-1:0] wr_data = '0, rd_data;
    logic          rd_valid, bist_busy, bist_done, bist_fail;

    logic [AWB-1:0] adress_b = '0, inj_adr_b = '0, fail_adr_b;
    logic           wr_en_b = 0, rd_en_b = 0, bist_start_b = 0, inj_en_b = 0;
    logic [DWB-1:0] wr_data_b = '0, rd_data_b;
    logic           rd_valid_b, bist_busy_b, bist_done_b, bist_fail_b;

    mem_bist #(.ADR_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clk(clk), .rst(rst), .adress(adress), .wr_en(wr_en), .rd_en(rd_en),
        .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
        .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done),
        .bist_fail(bist_fail), .fail_adr(fail_adr), .inj_en(inj_en), .inj_adr(inj_adr));

    mem_bist #(.ADR_SIZE(AWB), .DATA_SIZE(DWB)) dut_b (
        .clk(clk), .rst(rst), .adress(adress_b), .wr_en(wr_en_b), .rd_en(rd_en_b),
        .wr_data(wr_data_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .bist_start(bist_start_b), .bist_busy(bist_busy_b), .bist_done(bist_done_b),
        .bist_fail(bist_fail_b), .fail_adr(fail_adr_b), .inj_en(inj_en_b), .inj_adr(inj_adr_b));

    int checks = 0, errors = 0;
    logic [DW-1:0] model [1 << AW];
    logic [DW-1:0] exp_rd = '0;

    typedef struct { bit rd; int adr; bit one; } op_t;

    // March C- as an explicit list of operations, replayed against a plain memory array.
    function automatic void model_bist(input int aw, input int dw, input bit ie, input int ia,
                                       output int done_edge, output bit fail, output int fadr);
        op_t ops[$];
        longint unsigned mem[];
        longint unsigned ones, val;
        int n = 1 << aw;
        ones = (64'd1 << dw) - 1;
        mem = new[n];
        for (int a = 0; a < n; a++) ops.push_back('{0, a, 0});
        for (int a = 0; a < n; a++) begin ops.push_back('{1, a, 0}); ops.push_back('{0, a, 1}); end
        for (int a = 0; a < n; a++) begin ops.push_back('{1, a, 1}); ops.push_back('{0, a, 0}); end
        for (int a = n - 1; a >= 0; a--) begin ops.push_back('{1, a, 0}); ops.push_back('{0, a, 1}); end
        for (int a = n - 1; a >= 0; a--) begin ops.push_back('{1, a, 1}); ops.push_back('{0, a, 0}); end
        for (int a = 0; a < n; a++) ops.push_back('{1, a, 0});
        fail = 0; fadr = 0; done_edge = ops.size() + 1;
        for (int k = 0; k < ops.size(); k++) begin
            if (ops[k].rd) begin
                val = mem[ops[k].adr];
                if (ie && ops[k].adr == ia) val = val & ~64'd1;
                if (val != (ops[k].one ? ones : 64'd0)) begin
                    fail = 1; fadr = ops[k].adr; done_edge = k + 2;
                    return;
                end
            end else begin
                mem[ops[k].adr] = ops[k].one ? ones : 64'd0;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        step(); step();
        checks++;
        if ({rd_data, rd_valid, bist_busy, bist_done, bist_fail, fail_adr} !== '0) begin
            errors++;
            $display("FAIL reset_a got data=%h v=%b busy=%b done=%b fail=%b fadr=%0d want all 0",
                     rd_data, rd_valid, bist_busy, bist_done, bist_fail, fail_adr);
        end
        checks++;
        if ({rd_data_b, rd_valid_b, bist_busy_b, bist_done_b, bist_fail_b, fail_adr_b} !== '0) begin
            errors++;
            $display("FAIL reset_b got data=%h v=%b busy=%b done=%b want all 0",
                     rd_data_b, rd_valid_b, bist_busy_b, bist_done_b);
        end
        rst = 0;
        exp_rd = '0;
    endtask

    task automatic test_func_basic();
        adress = 4'd3; wr_data = 8'hA5; wr_en = 1;
        step();
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL wr_no_valid got %b want 0", rd_valid); end
        wr_en = 0; rd_en = 1;
        step();
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, 8'hA5}) begin
            errors++; $display("FAIL wr_then_rd got v=%b d=%h want v=1 d=a5", rd_valid, rd_data);
        end
        rd_en = 0;
        step();
        checks++;
        if ({rd_valid, rd_data} !== {1'b0, 8'hA5}) begin
            errors++; $display("FAIL rd_pulse_hold got v=%b d=%h want v=0 d=a5", rd_valid, rd_data);
        end
        adress = 4'd7; wr_data = 8'h3C; wr_en = 1; rd_en = 1;
        step();
        checks++;
        if ({rd_valid, rd_data} !== {1'b0, 8'hA5}) begin
            errors++; $display("FAIL wr_rd_collide got v=%b d=%h want v=0 d=a5", rd_valid, rd_data);
        end
        wr_en = 0;
        step();
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, 8'h3C}) begin
            errors++; $display("FAIL collide_readback got v=%b d=%h want v=1 d=3c", rd_valid, rd_data);
        end
        rd_en = 0;
        model[3] = 8'hA5; model[7] = 8'h3C; exp_rd = 8'h3C;
    endtask

    task automatic test_func_random();
        logic ev;
        for (int a = 0; a < (1 << AW); a++) begin
            adress = AW'(a); wr_data = DW'($urandom); wr_en = 1;
            model[a] = wr_data;
            step();
        end
        wr_en = 0;
        for (int i = 0; i < 200; i++) begin
            adress = AW'($urandom); wr_data = DW'($urandom);
            wr_en = ($urandom_range(0, 3) == 0); rd_en = $urandom_range(0, 1);
            inj_en = ($urandom_range(0, 3) == 0); inj_adr = AW'($urandom_range(0, 3) == 0 ? adress : $urandom);
            ev = 0;
            if (wr_en) model[adress] = wr_data;
            else if (rd_en) begin
                ev = 1;
                exp_rd = model[adress];
                if (inj_en && inj_adr == adress) exp_rd[0] = 1'b0;
            end
            step();
            checks++;
            if ({rd_valid, rd_data} !== {ev, exp_rd}) begin
                errors++;
                $display("FAIL func_rand[%0d] got v=%b d=%h want v=%b d=%h", i, rd_valid, rd_data, ev, exp_rd);
            end
        end
        wr_en = 0; rd_en = 0; inj_en = 0;
    endtask

    // Runs one test on the default instance and checks every edge up to one past the done edge.
    task automatic run_bist_a(input bit ie, input int ia, input bit noise, input string nm);
        int de, fadr;
        bit fl;
        model_bist(AW, DW, ie, ia, de, fl, fadr);
        inj_en = ie; inj_adr = AW'(ia);
        bist_start = 1;
        step();
        bist_start = 0;
        checks++;
        if ({bist_busy, bist_done, bist_fail} !== 3'b100) begin
            errors++; $display("FAIL %s_start got busy=%b done=%b fail=%b want 1 0 0", nm, bist_busy, bist_done, bist_fail);
        end
        for (int e = 1; e <= de + 1; e++) begin
            if (noise && e <= de) begin
                adress = AW'($urandom); wr_data = DW'($urandom);
                wr_en = $urandom_range(0, 1); rd_en = $urandom_range(0, 1); bist_start = $urandom_range(0, 1);
            end else begin
                wr_en = 0; rd_en = 0; bist_start = 0;
            end
            step();
            checks++;
            if (e < de) begin
                if ({bist_busy, bist_done, rd_valid} !== 3'b100) begin
                    errors++;
                    $display("FAIL %s_run E%0d got busy=%b done=%b rv=%b want 1 0 0", nm, e, bist_busy, bist_done, rd_valid);
                end
            end else if ({bist_busy, bist_done, bist_fail} !== {2'b01, fl} || (fl && fail_adr !== AW'(fadr))) begin
                errors++;
                $display("FAIL %s_done E%0d got busy=%b done=%b fail=%b fadr=%0d want 0 1 %b fadr=%0d",
                         nm, e, bist_busy, bist_done, bist_fail, fail_adr, fl, fadr);
            end
        end
        inj_en = 0;
    endtask

    task automatic test_bist_pass();
        run_bist_a(0, 0, 0, "pass");
        // The final element leaves every word zero.
        for (int a = 0; a < (1 << AW); a++) begin
            adress = AW'(a); rd_en = 1;
            step();
            checks++;
            if ({rd_valid, rd_data} !== {1'b1, 8'h00}) begin
                errors++; $display("FAIL post_pass_mem[%0d] got v=%b d=%h want v=1 d=00", a, rd_valid, rd_data);
            end
        end
        rd_en = 0;
        run_bist_a(0, 0, 1, "busy_ignore");
    endtask

    task automatic test_bist_fail();
        run_bist_a(1, 5, 0, "inj5");
        run_bist_a(1, 0, 0, "inj0");
        run_bist_a(1, 15, 0, "inj15");
        for (int i = 0; i < 3; i++) run_bist_a(1, $urandom_range(0, 15), 0, "inj_rand");
    endtask

    task automatic test_reset_midtest();
        adress = 4'd9; wr_data = 8'h5A; wr_en = 1;
        step();
        wr_en = 0; rd_en = 1;
        step();
        rd_en = 0;
        bist_start = 1;
        step();
        bist_start = 0;
        for (int e = 1; e < 40; e++) step();
        rst = 1;
        step();
        checks++;
        if ({rd_data, rd_valid, bist_busy, bist_done, bist_fail, fail_adr} !== '0) begin
            errors++;
            $display("FAIL midtest_reset got data=%h v=%b busy=%b done=%b fail=%b want all 0",
                     rd_data, rd_valid, bist_busy, bist_done, bist_fail);
        end
        rst = 0;
        step();
        checks++;
        if ({bist_busy, bist_done} !== 2'b00) begin
            errors++; $display("FAIL midtest_idle got busy=%b done=%b want 0 0", bist_busy, bist_done);
        end
        run_bist_a(0, 0, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        int de, fadr, per;
        bit fl, ed;
        model_bist(AWB, DWB, 0, 0, de, fl, fadr);
        per = de + 1;
        bist_start_b = 1;
        step();
        checks++;
        if ({bist_busy_b, bist_done_b} !== 2'b10) begin
            errors++; $display("FAIL b2b_start got busy=%b done=%b want 1 0", bist_busy_b, bist_done_b);
        end
        for (int e = 1; e <= 2 * per + de; e++) begin
            step();
            ed = ((e % per) == de);
            checks++;
            if ({bist_busy_b, bist_done_b, bist_fail_b} !== {!ed, ed, 1'b0}) begin
                errors++;
                $display("FAIL b2b E%0d got busy=%b done=%b fail=%b want %b %b 0", e, bist_busy_b, bist_done_b, bist_fail_b, !ed, ed);
            end
        end
        bist_start_b = 0;
        step();
        checks++;
        if ({bist_busy_b, bist_done_b} !== 2'b01) begin
            errors++; $display("FAIL b2b_hold got busy=%b done=%b want 0 1", bist_busy_b, bist_done_b);
        end
    endtask

    initial begin
        test_reset();
        test_func_basic();
        test_func_random();
        test_bist_pass();
        test_bist_fail();
        test_reset_midtest();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
